spi_pwm_reg_ctrl: RTL and testbench



---
 rtl/pwm_cfg_pkg.sv | 24 ++
 rtl/sync_edge_det.sv | 37 +++
 rtl/spi_pwm_reg_ctrl.sv | 140 ++++++++++++++
 tb/tb_spi_pwm_reg_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pwm_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cfg_pkg
// Brief    : Shared constants and FSM state type for the PWM SPI config port.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_cfg_pkg;

   localparam int FRAME_BITS = 16;

   localparam int ADDR_EN_OUT_LO = 0;
   localparam int ADDR_EN_OUT_HI = 1;
   localparam int ADDR_EN_PWM_LO = 2;
   localparam int ADDR_EN_PWM_HI = 3;
   localparam int ADDR_DUTY      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Multi-flop synchroniser with one extra flop for edge detection.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], din};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign level = r_sync[SYNC_STAGES-1];
   assign rise  =  level & ~r_prev;
   assign fall  = ~level &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_pwm_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_pwm_reg_ctrl
// Brief    : Write-only SPI (mode 0) target loading five 8-bit PWM registers.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pwm_reg_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = pwm_cfg_pkg::FRAME_BITS,
   parameter int MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk_in,
   input  logic       copi_in,
   input  logic       ncs_in,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       frame_err
);

   import pwm_cfg_pkg::*;

   localparam int CW = $clog2(FRAME_BITS + 2);
   localparam logic [CW-1:0] C_CNT_FULL = CW'(FRAME_BITS);
   localparam logic [CW-1:0] C_CNT_SAT  = CW'(FRAME_BITS + 1);

   logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
   logic w_copi_lvl, w_copi_rise, w_copi_fall;
   logic w_ncs_lvl,  w_ncs_rise,  w_ncs_fall;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(sclk_in),
      .level(w_sclk_lvl), .rise(w_sclk_rise), .fall(w_sclk_fall)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst(rst), .din(copi_in),
      .level(w_copi_lvl), .rise(w_copi_rise), .fall(w_copi_fall)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst(rst), .din(ncs_in),
      .level(w_ncs_lvl), .rise(w_ncs_rise), .fall(w_ncs_fall)
   );

   logic w_unused_sigs;
   assign w_unused_sigs = &{1'b0, w_sclk_lvl, w_sclk_fall, w_copi_rise,
                            w_copi_fall, w_ncs_lvl};

   state_t                r_state, w_next_state;
   logic [CW-1:0]         r_cnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic [7:0]            r_regs [0:MAX_ADDR];
   logic                  r_wr_strobe, r_frame_err;

   logic       w_is_write;
   logic [6:0] w_addr;
   logic [7:0] w_data;
   logic       w_len_ok, w_addr_ok, w_do_write, w_do_err;

   assign w_is_write = r_shift[FRAME_BITS-1];
   assign w_addr     = r_shift[FRAME_BITS-2 -: 7];
   assign w_data     = r_shift[7:0];
   assign w_len_ok   = (r_cnt == C_CNT_FULL);
   assign w_addr_ok  = (w_addr <= 7'(MAX_ADDR));
   assign w_do_write = w_len_ok & w_is_write & w_addr_ok;
   // Read requests of correct length are dropped without flagging an error.
   assign w_do_err   = ~w_len_ok | (w_is_write & ~w_addr_ok);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_ncs_fall) w_next_state = SHIFT;
         SHIFT:   if (w_ncs_rise) w_next_state = COMMIT;
         COMMIT:  w_next_state = w_ncs_fall ? SHIFT : IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_shift     <= '0;
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
         for (int i = 0; i <= MAX_ADDR; i++) r_regs[i] <= 8'h00;
      end else begin
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_ncs_fall) begin
                  r_cnt   <= '0;
                  r_shift <= '0;
               end
            end
            SHIFT: begin
               if (!w_ncs_rise && w_sclk_rise) begin
                  r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_lvl};
                  if (r_cnt != C_CNT_SAT) r_cnt <= r_cnt + 1'b1;
               end
            end
            COMMIT: begin
               if (w_do_write) begin
                  for (int i = 0; i <= MAX_ADDR; i++)
                     if (w_addr == 7'(i)) r_regs[i] <= w_data;
                  r_wr_strobe <= 1'b1;
               end else if (w_do_err) begin
                  r_frame_err <= 1'b1;
               end
               if (w_ncs_fall) begin
                  r_cnt   <= '0;
                  r_shift <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign en_reg_out_7_0  = r_regs[ADDR_EN_OUT_LO];
   assign en_reg_out_15_8 = r_regs[ADDR_EN_OUT_HI];
   assign en_reg_pwm_7_0  = r_regs[ADDR_EN_PWM_LO];
   assign en_reg_pwm_15_8 = r_regs[ADDR_EN_PWM_HI];
   assign pwm_duty_cycle  = r_regs[ADDR_DUTY];
   assign wr_strobe       = r_wr_strobe;
   assign frame_err       = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_pwm_reg_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_pwm_reg_ctrl
// Brief    : Table-driven bench for spi_pwm_reg_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_pwm_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk_in = 1'b0;
   logic       copi_in = 1'b0;
   logic       ncs_in  = 1'b1;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8, pwm_duty_cycle;
   logic       wr_strobe, frame_err;

   int n_app = 0;
   int n_bad = 0;
   int n_strb = 0;
   int n_err  = 0;

   spi_pwm_reg_ctrl #(.SYNC_STAGES(2), .FRAME_BITS(16), .MAX_ADDR(4)) dut (
      .clk(clk), .rst(rst),
      .sclk_in(sclk_in), .copi_in(copi_in), .ncs_in(ncs_in),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle),
      .wr_strobe(wr_strobe), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Pulse counters: a pulse held longer than one cycle counts more than once.
   always @(negedge clk) begin
      if (wr_strobe === 1'b1) n_strb++;
      if (frame_err === 1'b1) n_err++;
   end

   typedef struct {
      logic [31:0] bits;
      int          nbits;
      int          gap;
      bit          chk;
      logic [7:0]  r0, r1, r2, r3, r4;
      int          strb;
      int          err;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string name, input int act, input int exp);
      n_app++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                          input int es, input int ee);
      chk({tag, " out_7_0"},  int'(en_reg_out_7_0),  int'(e0));
      chk({tag, " out_15_8"}, int'(en_reg_out_15_8), int'(e1));
      chk({tag, " pwm_7_0"},  int'(en_reg_pwm_7_0),  int'(e2));
      chk({tag, " pwm_15_8"}, int'(en_reg_pwm_15_8), int'(e3));
      chk({tag, " duty"},     int'(pwm_duty_cycle),  int'(e4));
      chk({tag, " strobes"},  n_strb, es);
      chk({tag, " errors"},   n_err,  ee);
   endtask

   // SCLK period 80 ns = 8 system clocks; bits sent MSB first from bits[31].
   task automatic spi_frame(input logic [31:0] bits, input int nbits, input int gap);
      ncs_in = 1'b0;
      #40;
      for (int i = 0; i < nbits; i++) begin
         copi_in = bits[31-i];
         #40 sclk_in = 1'b1;
         #40 sclk_in = 1'b0;
      end
      #40;
      ncs_in  = 1'b1;
      copi_in = 1'b0;
      #(gap);
   endtask

   initial begin
      vt[0] = '{32'h8055_0000, 16, 200, 1'b1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0};
      vt[1] = '{32'h84FF_0000, 16,  10, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0};
      vt[2] = '{32'h8280_0000, 16,  10, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0};
      vt[3] = '{32'h83A5_0000, 16, 200, 1'b1, 8'h55, 8'h00, 8'h80, 8'hA5, 8'hFF, 4, 0};
      vt[4] = '{32'h8712_0000, 16, 200, 1'b1, 8'h55, 8'h00, 8'h80, 8'hA5, 8'hFF, 4, 1};
      vt[5] = '{32'h0412_0000, 16, 200, 1'b1, 8'h55, 8'h00, 8'h80, 8'hA5, 8'hFF, 4, 1};
      vt[6] = '{32'h81C3_0000, 15, 200, 1'b1, 8'h55, 8'h00, 8'h80, 8'hA5, 8'hFF, 4, 2};
      vt[7] = '{32'h81C3_0000, 16, 200, 1'b1, 8'h55, 8'hC3, 8'h80, 8'hA5, 8'hFF, 5, 2};
      vt[8] = '{32'h8177_8000, 17, 200, 1'b1, 8'h55, 8'hC3, 8'h80, 8'hA5, 8'hFF, 5, 3};
      vt[9] = '{32'h8199_0000, 16, 200, 1'b1, 8'h55, 8'h99, 8'h80, 8'hA5, 8'hFF, 6, 3};

      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         spi_frame(vt[i].bits, vt[i].nbits, vt[i].gap);
         if (vt[i].chk) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vt[i].r0, vt[i].r1, vt[i].r2,
                    vt[i].r3, vt[i].r4, vt[i].strb, vt[i].err);
            @(negedge clk);
         end
      end

      // Reset in the middle of a frame: 10 bits of 16'h8033, then rst.
      begin
         logic [15:0] part;
         part   = 16'h8033;
         ncs_in = 1'b0;
         #40;
         for (int b = 0; b < 10; b++) begin
            copi_in = part[15-b];
            #40 sclk_in = 1'b1;
            #40 sclk_in = 1'b0;
         end
      end
      @(negedge clk);
      rst     = 1'b1;
      ncs_in  = 1'b1;
      copi_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk_all("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6, 3);

      @(negedge clk);
      spi_frame(32'h8033_0000, 16, 200);
      @(posedge clk);
      #1;
      chk_all("post_rst", 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 7, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
